// File: rtl/sobel_pkg.sv
// Shared types, kernel weights and the saturating magnitude helper for Sobel filtering.
package sobel_pkg;

    localparam int PIX_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int K_EDGE   = 1;
    localparam int K_CENTRE = 2;

    // |gx|+|gy| clamped to the largest pix_w-bit unsigned value.
    function automatic int sat_mag(input int gx, input int gy, input int pix_w);
        int ax;
        int ay;
        int lim;
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        lim = (1 << pix_w) - 1;
        return ((ax + ay) > lim) ? lim : (ax + ay);
    endfunction

endpackage

// File: rtl/sobel_window_calc.sv
// Combinational Sobel kernel: a 3x3 window (index row*3+col, col 2 rightmost) in, saturated magnitude out.
module sobel_window_calc
    import sobel_pkg::*;
#(
    parameter int PIX_W = sobel_pkg::PIX_W
) (
    input  logic [8:0][PIX_W-1:0] i_win,
    output logic [PIX_W-1:0]      o_mag
);

    localparam int GW = PIX_W + 3;

    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;

    assign w_gx = GW'((K_EDGE * int'(i_win[2]) + K_CENTRE * int'(i_win[5]) + K_EDGE * int'(i_win[8]))
                    - (K_EDGE * int'(i_win[0]) + K_CENTRE * int'(i_win[3]) + K_EDGE * int'(i_win[6])));

    assign w_gy = GW'((K_EDGE * int'(i_win[6]) + K_CENTRE * int'(i_win[7]) + K_EDGE * int'(i_win[8]))
                    - (K_EDGE * int'(i_win[0]) + K_CENTRE * int'(i_win[1]) + K_EDGE * int'(i_win[2])));

    assign o_mag = PIX_W'(sat_mag(int'(w_gx), int'(w_gy), PIX_W));

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer: streams pixels through two line buffers and a sliding window, emitting interior gradients.
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int PIX_W = sobel_pkg::PIX_W,
    parameter int IMG_W = 8,
    parameter int IMG_H = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [PIX_W-1:0]             i_in_pix,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [PIX_W-1:0]             o_out_pix,
    output logic [$clog2(IMG_H-2)-1:0]   o_out_row,
    output logic [$clog2(IMG_W-2)-1:0]   o_out_col,
    output state_t                       o_state
);

    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);
    localparam int ORW = $clog2(IMG_H - 2);
    localparam int OCW = $clog2(IMG_W - 2);

    state_t              r_state;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic                r_out_valid;
    logic [PIX_W-1:0]    r_out_pix;
    logic [ORW-1:0]      r_out_row;
    logic [OCW-1:0]      r_out_col;

    logic [PIX_W-1:0]    r_lb0 [IMG_W];
    logic [PIX_W-1:0]    r_lb1 [IMG_W];
    // Only the two older window columns are stored; the newest column arrives with the pixel.
    logic [PIX_W-1:0]    r_win [3][2];

    logic                   w_take;
    logic                   w_last;
    logic                   w_emit;
    logic [2:0][PIX_W-1:0]  w_col_new;
    logic [8:0][PIX_W-1:0]  w_win;
    logic [PIX_W-1:0]       w_mag;

    assign o_in_ready = (r_state == ACTIVE) && (!r_out_valid || i_out_ready);
    assign w_take     = i_in_valid && o_in_ready;
    assign w_last     = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
    assign w_emit     = w_take && (r_row >= RW'(2)) && (r_col >= CW'(2));

    assign w_col_new[0] = r_lb0[r_col];
    assign w_col_new[1] = r_lb1[r_col];
    assign w_col_new[2] = i_in_pix;

    always_comb begin
        w_win = '0;
        for (int r = 0; r < 3; r++) begin
            w_win[r*3 + 0] = r_win[r][0];
            w_win[r*3 + 1] = r_win[r][1];
            w_win[r*3 + 2] = w_col_new[r];
        end
    end

    sobel_window_calc #(
        .PIX_W (PIX_W)
    ) u_calc (
        .i_win (w_win),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= ACTIVE;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_take) begin
                        if (r_col == CW'(IMG_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_out_valid) r_state <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A new result can only load when the previous one is gone or leaving, so nothing is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_pix   <= w_mag;
            r_out_row   <= ORW'(r_row - RW'(2));
            r_out_col   <= OCW'(r_col - CW'(2));
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= i_in_pix;
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col_new[r];
            end
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_out_valid = r_out_valid;
    assign o_out_pix   = r_out_pix;
    assign o_out_row   = r_out_row;
    assign o_out_col   = r_out_col;
    assign o_state     = r_state;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Scoreboard bench for sobel_stream_ctrl: frame-level model feeds an expected queue, monitor pops on output.
module tb_sobel_stream_ctrl;
    import sobel_pkg::*;

    localparam int PW = 11;
    localparam int IW = 8;
    localparam int IH = 7;
    localparam int NRES = (IW - 2) * (IH - 2);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           done;
    logic           in_valid;
    logic           in_ready;
    logic [PW-1:0]  in_pix;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  out_pix;
    logic [2:0]     out_row;
    logic [2:0]     out_col;
    state_t         state_dbg;

    sobel_stream_ctrl #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_pix    (in_pix),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_pix   (out_pix),
        .o_out_row   (out_row),
        .o_out_col   (out_col),
        .o_state     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_got   = 0;
    int n_done  = 0;
    logic stall = 1'b0;

    logic [16:0] exp_q[$];
    int img [IH][IW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model straight from the frame array
    function automatic logic [16:0] model(input int r, input int c);
        int gx, gy, m;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 2047) m = 2047;
        return {3'(r - 2), 3'(c - 2), 11'(m)};
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                case (mode)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c >= 4) ? 255 : 0;
                    2: img[r][c] = (r >= 3) ? 255 : 0;
                    3: img[r][c] = (c >= 4) ? 2047 : 0;
                    default: img[r][c] = int'($urandom_range(0, 2047));
                endcase
    endtask

    // sink: random out_ready unless a stall is forced
    always @(posedge clk) begin
        #1;
        if (!stall) out_ready = ($urandom_range(0, 3) != 0);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            if (out_valid && out_ready) begin
                logic [16:0] e;
                n_got++;
                if (exp_q.size() == 0) begin
                    check("extra_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_row", 32'(out_row), 32'(e[16:14]));
                    check("out_col", 32'(out_col), 32'(e[13:11]));
                    check("out_pix", 32'(out_pix), 32'(e[10:0]));
                end
            end
        end
    end

    task automatic send_pix(input int p);
        logic hs;
        int budget;
        repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pix   = PW'(p);
        budget   = 200;
        hs       = 1'b0;
        while (!hs && budget > 0) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            budget--;
        end
        if (!hs) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int mode, input int abort_at);
        int g0, d0, budget, idx;
        fill(mode);
        g0 = n_got;
        d0 = n_done;
        start_frame();
        idx = 0;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (abort_at >= 0 && idx == abort_at) begin
                    rst_n = 1'b0;
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_out_valid", 32'(out_valid), 32'd0);
                    check("rst_out_pix", 32'(out_pix), 32'd0);
                    check("rst_in_ready", 32'(in_ready), 32'd0);
                    exp_q.delete();
                    @(posedge clk); #1 rst_n = 1'b1;
                    return;
                end
                if (idx == 10) start = 1'b1;
                if (idx == 12) start = 1'b0;
                if (r >= 2 && c >= 2) exp_q.push_back(model(r, c));
                send_pix(img[r][c]);
                idx++;
            end
        end
        start = 1'b0;
        budget = 400;
        while (n_done == d0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("done_seen", 32'(n_done != d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(n_done - d0), 32'd1);
        check("n_results", 32'(n_got - g0), 32'(NRES));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic stall_proc();
        int base, budget;
        logic [16:0] hold;
        base = n_got;
        budget = 3000;
        while (n_got < base + 10 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk); #1;
        stall = 1'b1;
        out_ready = 1'b0;
        budget = 200;
        do begin
            @(negedge clk);
            budget--;
        end while (!out_valid && budget > 0);
        check("stall_valid", 32'(out_valid), 32'd1);
        hold = {out_row, out_col, out_pix};
        repeat (5) begin
            @(negedge clk);
            check("stall_hold", 32'({out_row, out_col, out_pix}), 32'(hold));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_pix = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_pix", 32'(out_pix), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(3, -1);
        fork
            run_frame(1, -1);
            stall_proc();
        join
        run_frame(1, 20);
        run_frame(1, -1);
        run_frame(4, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
